sub_serial4: RTL and testbench
==============================

Name: sub_serial4

Overview:
- Multi-cycle, slice-serial two's-complement subtractor computing diff = a − b − bin.
- Operands are processed 4 bits per clock, least-significant slice first, with the borrow registered between slices.
- Trades latency for area; feeds the accelerator datapath as the subtraction counterpart to the 4-bit carry-chain adder slices.
- Valid/ready handshake on input and output; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and ≥ 4; any other value is an elaboration error.
- NSLICE, WIDTH/4, derived localparam giving the number of 4-bit slices processed per operation. Not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept operands; equals (state==IDLE).
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  a − b − bin, mod 2^WIDTH.
- bout  out  1  final borrow; 1 iff unsigned a < b + bin.
- zero  out  1  diff == 0.
- ovf  out  1  signed overflow of a − b − bin.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, slice index=0, borrow reg=0, diff=0, bout=0, zero=0, ovf=0, out_valid=0.
  - in_ready reads 1 during and after reset.
  - Asserting rst_n mid-operation aborts it; no partial result is ever flagged valid.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, capture a, b into operand regs and bin into the borrow reg; clear the slice index; go to RUN.
  - RUN: in_ready=0. Each cycle, for slice k = index:
    - compute a[4k+3:4k] + ~b[4k+3:4k] + ~borrow as a 4-bit add with carry;
    - write the 4-bit sum to diff[4k+3:4k];
    - set borrow = ~carry_out;
    - increment the index.
    - On the cycle that processes slice NSLICE−1, register bout=final borrow, zero=(full diff incl. this slice == 0), ovf=(a[MSB]≠b[MSB]) && (diff[MSB]≠a[MSB]). Then set out_valid=1 and go to DONE.
  - DONE: in_ready=0. out_valid, diff, bout, zero and ovf are held stable until out_ready is sampled high. On out_valid && out_ready, clear out_valid and go to IDLE.
- Latency: out_valid rises on exactly the NSLICE-th rising edge after the accepting edge (4 edges for WIDTH=16).
- Throughput: minimum NSLICE+2 cycles per operation (accept cycle, NSLICE RUN cycles, ≥1 DONE cycle). There is no accept-during-DONE bypass.
- in_valid outside IDLE is ignored. Operand inputs need not be held after acceptance.
- diff is only meaningful while out_valid=1. It changes slice-by-slice during RUN and retains its last value in IDLE.
- Overflow uses the two's-complement rule on the a − b terms. When bin=1 and a − b is exactly the minimum signed value, the result wraps and ovf follows the MSB rule above.
- out_ready may be high before out_valid; completion then occurs on the first DONE cycle.
- Must not generate latches. No combinational path from inputs to outputs.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0235, bin=0 -> diff=0x0FFF, bout=0, zero=0, ovf=0; out_valid exactly 4 edges after accept.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0, ovf=0; borrow propagates through all 4 slices.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, ovf=1, bout=0; also a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, bout=1.
- a=0x5555, b=0x5554, bin=1 -> diff=0x0000, zero=1, bout=0, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid while driving in_valid=1 with new operands -> outputs stable, in_ready=0, nothing accepted. Raise out_ready -> out_valid falls and in_ready=1 on the next cycle; the new operands are then accepted and give the correct result.
- Assert rst_n low after 2 RUN cycles -> immediately out_valid=0, diff=0, in_ready=1. After release, the next operation (0x00FF−0x0001) gives 0x00FE with normal latency.

Source files
------------

// File: rtl/sub_serial4_if.sv
// sub_serial4_if: operand/result bundle for the slice-serial subtractor.
// Ports: in_valid/in_ready/a/b/bin (operand side), out_valid/out_ready/diff/bout/zero/ovf (result side).
// master = producer/consumer around the block, slave = the subtractor itself.
interface sub_serial4_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/sub_serial4.sv
// sub_serial4: slice-serial a - b - bin, 4 bits per clock, LSB slice first, borrow registered between slices.
// Latency: out_valid rises NSLICE edges after the accepting edge; one operation in flight (>= NSLICE+2 cycles each).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Ports: clk, rst_n, bus (slave modport).
module sub_serial4 #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  sub_serial4_if.slave  bus
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("sub_serial4: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              borrow_q, borrow_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [IDXW+1:0]   base;
  logic [3:0]        slice_a, slice_b;
  logic [4:0]        slice_sum;
  logic              last_slice;
  logic [WIDTH-1:0]  diff_upd;

  assign base       = {idx_q, 2'b00};
  assign slice_a    = a_q[base +: 4];
  assign slice_b    = b_q[base +: 4];
  // a - b - borrow == a + ~b + ~borrow; carry out of the slice is the inverse of the borrow out.
  assign slice_sum  = {1'b0, slice_a} + {1'b0, ~slice_b} + {4'b0000, ~borrow_q};
  assign last_slice = (idx_q == IDXW'(NSLICE - 1));

  always_comb begin
    diff_upd             = diff_q;
    diff_upd[base +: 4]  = slice_sum[3:0];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    borrow_d    = borrow_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d   = diff_upd;
        borrow_d = ~slice_sum[4];
        idx_d    = idx_q + 1'b1;
        if (last_slice) begin
          // Flags are taken from the fully assembled result, including the slice written this cycle.
          bout_d      = ~slice_sum[4];
          zero_d      = (diff_upd == '0);
          ovf_d       = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_upd[WIDTH-1] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      borrow_q    <= borrow_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sub_serial4.sv
// tb_sub_serial4: directed-vector bench for sub_serial4 at WIDTH=16.
// Latency: checks out_valid on exactly the 4th edge after accept.
// Backpressure: holds out_ready low with in_valid pending, then checks release and reset abort.
module tb_sub_serial4;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  sub_serial4_if #(.WIDTH(WIDTH)) bus_if ();

  sub_serial4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge: present operands, expect IDLE, accept on the next edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
    bus_if.in_valid = 1'b1;
    bus_if.a        = a;
    bus_if.b        = b;
    bus_if.bin      = bin;
    chk("in_ready_before_accept", {31'd0, bus_if.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.a        = 16'hDEAD;
    bus_if.b        = 16'hBEEF;
    bus_if.bin      = 1'b1;
  endtask

  // Called #1 after the accepting edge; counts edges up to the result.
  task automatic wait_result(input string tag, input logic [15:0] ed, input logic eb,
                             input logic ez, input logic eo);
    for (int k = 1; k <= NSLICE; k++) begin
      @(posedge clk); #1;
      chk({tag, "_out_valid_timing"}, {31'd0, bus_if.out_valid}, (k == NSLICE) ? 32'd1 : 32'd0);
      chk({tag, "_in_ready_busy"}, {31'd0, bus_if.in_ready}, 32'd0);
    end
    chk({tag, "_diff"}, {16'd0, bus_if.diff}, {16'd0, ed});
    chk({tag, "_bout"}, {31'd0, bus_if.bout}, {31'd0, eb});
    chk({tag, "_zero"}, {31'd0, bus_if.zero}, {31'd0, ez});
    chk({tag, "_ovf"},  {31'd0, bus_if.ovf},  {31'd0, eo});
  endtask

  task automatic release_result(input string tag);
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    chk({tag, "_out_valid_clear"}, {31'd0, bus_if.out_valid}, 32'd0);
    chk({tag, "_in_ready_back"}, {31'd0, bus_if.in_ready}, 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input logic [15:0] ed, input logic eb, input logic ez, input logic eo);
    start_op(a, b, bin);
    wait_result(tag, ed, eb, ez, eo);
    release_result(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.bin       = 1'b0;
    bus_if.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, bus_if.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("rst_diff",      {16'd0, bus_if.diff},      32'd0);
    chk("rst_flags",     {29'd0, bus_if.bout, bus_if.zero, bus_if.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: a, b, bin -> diff, bout, zero, ovf.
    run_vec("v1234",   16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    run_vec("vborrow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_vec("vovfneg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    run_vec("vovfpos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
    run_vec("vzero",   16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_vec("vbinonly",16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    // a - b is exactly 0x8000; bin wraps it to 0x7FFF with the sign flipped from a.
    run_vec("vminwrap",16'hFFFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held while new operands wait on in_valid.
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_result("bp", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    bus_if.in_valid = 1'b1;
    bus_if.a        = 16'h00FF;
    bus_if.b        = 16'h0010;
    bus_if.bin      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
      chk("bp_hold_in_ready",  {31'd0, bus_if.in_ready},  32'd0);
      chk("bp_hold_diff",      {16'd0, bus_if.diff},      32'h0000FFFF);
      chk("bp_hold_bout",      {31'd0, bus_if.bout},      32'd1);
    end
    release_result("bp");
    start_op(16'h00FF, 16'h0010, 1'b0);
    wait_result("bp_next", 16'h00EF, 1'b0, 1'b0, 1'b0);
    release_result("bp_next");

    // Reset in the middle of RUN aborts the operation.
    start_op(16'h1234, 16'h0235, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("abort_diff",      {16'd0, bus_if.diff},      32'd0);
    chk("abort_in_ready",  {31'd0, bus_if.in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_still_idle", {31'd0, bus_if.out_valid}, 32'd0);
    run_vec("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
